risc_mem_arbiter: RTL
=====================

Name: risc_mem_arbiter

Overview:
- Shares the single CPU memory port between three requesters: instruction fetch (IF), load/store data (LS) and an external DMA engine.
- Priority follows the program-sequencing FSM state code.
- Each granted transaction is held until the memory acknowledges it, times out, or the requester withdraws.
- A starvation counter guarantees DMA forward progress.
- Sits between the program FSM / datapath and the memory interface.

Parameters:
- TIMEOUT, 15: maximum BUSY cycles without mem_rdy before forced release; range 1..255.
- STARVE_LIMIT, 4: number of lost arbitrations after which a pending DMA request wins; range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req_i  input  3  request vector: bit0 IF, bit1 LS, bit2 DMA; level, held until done/timeout
- cpu_state  input  3  program FSM state code: 0 RESET, 1 FETCH_INSTR, 2 READ_OPS, 3 EXECUTE, 4 WRITEBACK
- mem_rdy  input  1  memory completion strobe, sampled only in BUSY
- gnt_o  output  3  one-hot grant, registered
- mem_cs  output  1  memory chip select, high throughout BUSY
- done_o  output  3  one-hot, one-cycle completion pulse to the granted requester
- timeout_o  output  1  one-cycle pulse on forced release
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; gnt_o=0, mem_cs=0, done_o=0, timeout_o=0, busy_o=0; wait and starve counters 0.
- Reset asserted mid-transaction aborts it immediately. No done or timeout pulse is produced.
- States: IDLE, BUSY, RELEASE. Encoding is 2 bits; the unused code returns to IDLE.

IDLE:
- If req_i != 0 at a rising edge, register the winner into gnt_o, go to BUSY, clear the wait counter.
- Grant is visible the cycle after the request is first seen (1-cycle latency).
- No request: stay in IDLE, all outputs 0.

Priority, evaluated in IDLE:
- DMA starvation override first: if req_i[2]=1 and starve count >= STARVE_LIMIT, DMA wins.
- Otherwise, if cpu_state==3 (EXECUTE): LS > IF > DMA.
- Otherwise: IF > LS > DMA.
- cpu_state values 5..7 are treated as non-EXECUTE.

Starve counter (4-bit):
- Increments, saturating at 15, on each decision where DMA requested and lost.
- Clears on a DMA grant.
- Unchanged when DMA is not requesting.

BUSY:
- mem_cs=1, busy_o=1, gnt_o held stable.
- mem_rdy=1 at an edge: done_o[winner] pulses the next cycle, gnt_o and mem_cs drop, go to RELEASE.
- Granted requester's req bit drops before mem_rdy: abort. Go to RELEASE with no done and no timeout pulse.
- Wait counter (8-bit) increments each BUSY cycle. If it reaches TIMEOUT-1 without mem_rdy: timeout_o pulses the next cycle, grant drops, go to RELEASE.
- mem_rdy and the timeout condition in the same cycle: mem_rdy wins (done, no timeout).
- mem_rdy and a request drop in the same cycle: done wins.
- Changes to other req bits or to cpu_state during BUSY are ignored.

RELEASE:
- One-cycle bus turnaround. gnt_o=0, mem_cs=0, busy_o=1.
- Always goes to IDLE.
- Minimum gap between grants is 2 cycles (RELEASE + IDLE).

Other:
- done_o and timeout_o are mutually exclusive and never coincide with gnt_o being high.
- Invariant: gnt_o has at most one bit set.

Decomposition:
- Shared package/header (risc_pkg): the cpu_state codes (RESET_STATE=0, FETCH_INSTR=1, READ_OPS=2, EXECUTE=3, WRITEBACK=4), arbiter state codes, and requester index constants (REQ_IF=0, REQ_LS=1, REQ_DMA=2).
- The program FSM and this block both use these codes.
- One natural sub-module, risc_prio_sel: combinational priority/override selector taking req_i, cpu_state and the starve_hit flag, returning a one-hot winner. The FSM and counters stay in the top module.

Test Plan:
- Reset, then req_i=3'b001 with cpu_state=1: gnt_o=001 one cycle later, mem_cs=1. mem_rdy pulse after 3 cycles gives done_o=001 for exactly one cycle, then RELEASE, then IDLE.
- req_i=3'b011 simultaneously, cpu_state=3: gnt_o=010. Same request with cpu_state=1: gnt_o=001.
- DMA held with IF re-requesting continuously and mem_rdy after 1 cycle each: IF wins 4 times, DMA wins the 5th decision, starve count then reads 0.
- Granted LS, mem_rdy held 0, TIMEOUT=15: timeout_o pulses exactly 15 cycles after the grant, no done_o. Also cover mem_rdy=1 on the 15th cycle, which must give done_o, not timeout.
- Granted IF drops its req mid-BUSY: grant released, no done_o or timeout_o, next pending request granted 2 cycles later.
- reset_n low during BUSY: all outputs 0 asynchronously. After release, a fresh request is granted in 1 cycle.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared codes for the program-sequencing FSM and the memory arbiter.
package risc_pkg;

    localparam logic [2:0] RESET_STATE = 3'd0;
    localparam logic [2:0] FETCH_INSTR = 3'd1;
    localparam logic [2:0] READ_OPS    = 3'd2;
    localparam logic [2:0] EXECUTE     = 3'd3;
    localparam logic [2:0] WRITEBACK   = 3'd4;

    localparam int REQ_IF  = 0;
    localparam int REQ_LS  = 1;
    localparam int REQ_DMA = 2;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_BUSY    = 2'b01,
        ARB_RELEASE = 2'b10
    } arb_state_e;

endpackage

// File: rtl/risc_prio_sel.sv
// Combinational winner select: DMA starvation override, then state-dependent priority.
module risc_prio_sel
    import risc_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [2:0] cpu_state,
    input  logic       starve_hit,
    output logic [2:0] winner
);

    always_comb begin
        winner = 3'b000;
        if (starve_hit && req_i[REQ_DMA]) begin
            winner[REQ_DMA] = 1'b1;
        end else if (cpu_state == EXECUTE) begin
            // Loads/stores in flight outrank the next fetch during EXECUTE
            if      (req_i[REQ_LS])  winner[REQ_LS]  = 1'b1;
            else if (req_i[REQ_IF])  winner[REQ_IF]  = 1'b1;
            else if (req_i[REQ_DMA]) winner[REQ_DMA] = 1'b1;
        end else begin
            if      (req_i[REQ_IF])  winner[REQ_IF]  = 1'b1;
            else if (req_i[REQ_LS])  winner[REQ_LS]  = 1'b1;
            else if (req_i[REQ_DMA]) winner[REQ_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Three-way memory port arbiter (IF / LS / DMA) with timeout, abort and DMA anti-starvation.
module risc_mem_arbiter
    import risc_pkg::*;
#(
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req_i,
    input  logic [2:0] cpu_state,
    input  logic       mem_rdy,
    output logic [2:0] gnt_o,
    output logic       mem_cs,
    output logic [2:0] done_o,
    output logic       timeout_o,
    output logic       busy_o
);

    arb_state_e state;
    logic [7:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic [2:0] winner;
    logic       starve_hit;

    assign starve_hit = (starve_cnt >= 4'(STARVE_LIMIT));
    assign busy_o     = (state != ARB_IDLE);

    risc_prio_sel u_prio_sel (
        .req_i      (req_i),
        .cpu_state  (cpu_state),
        .starve_hit (starve_hit),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            gnt_o      <= 3'b000;
            mem_cs     <= 1'b0;
            done_o     <= 3'b000;
            timeout_o  <= 1'b0;
            wait_cnt   <= 8'd0;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    done_o    <= 3'b000;
                    timeout_o <= 1'b0;
                    if (req_i != 3'b000) begin
                        gnt_o    <= winner;
                        mem_cs   <= 1'b1;
                        wait_cnt <= 8'd0;
                        state    <= ARB_BUSY;
                        if (winner[REQ_DMA])
                            starve_cnt <= 4'd0;
                        else if (req_i[REQ_DMA] && starve_cnt != 4'hF)
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                ARB_BUSY: begin
                    // Completion outranks both withdrawal and timeout
                    if (mem_rdy) begin
                        done_o <= gnt_o;
                        gnt_o  <= 3'b000;
                        mem_cs <= 1'b0;
                        state  <= ARB_RELEASE;
                    end else if ((req_i & gnt_o) == 3'b000) begin
                        gnt_o  <= 3'b000;
                        mem_cs <= 1'b0;
                        state  <= ARB_RELEASE;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        gnt_o     <= 3'b000;
                        mem_cs    <= 1'b0;
                        state     <= ARB_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ARB_RELEASE: begin
                    done_o    <= 3'b000;
                    timeout_o <= 1'b0;
                    state     <= ARB_IDLE;
                end
                default: begin
                    gnt_o     <= 3'b000;
                    mem_cs    <= 1'b0;
                    done_o    <= 3'b000;
                    timeout_o <= 1'b0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
